// File: rtl/init_pkg.sv
// Shared types for the initialization sequencer and the consumers that
// watch its status.
package init_pkg;

    // One-hot initialization status sampled by downstream consumers.
    typedef struct packed {
        bit INITIALIZED;
        bit NOT_INITIALIZED;
    } init_state_t;

    // Sequencer FSM encoding.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } init_fsm_t;

    // Builds a status word that is one-hot by construction.
    function automatic init_state_t make_status(input bit initialized);
        init_state_t s;
        s.INITIALIZED     = initialized;
        s.NOT_INITIALIZED = ~initialized;
        return s;
    endfunction

endpackage

// File: rtl/init_sequencer.sv
// Walks the write port of a clearable array through every entry with a
// constant fill value, waits a settle period, then reports the array as
// initialized. A new clear can be requested once the previous one is done.
module init_sequencer
    import init_pkg::*;
#(
    parameter int                DEPTH         = 32,
    parameter int                DATA_W        = 32,
    parameter logic [DATA_W-1:0] FILL_VALUE    = '0,
    parameter int                SETTLE_CYCLES = 4,
    parameter bit                AUTO_START    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     wr_ready_i,
    output logic                     wr_en_o,
    output logic [$clog2(DEPTH)-1:0] wr_addr_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output init_state_t              state_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    // Counter only needs to hold SETTLE_CYCLES-1; keep at least one bit.
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Handshake: a write transfers on a rising edge where wr_en_o and
    // wr_ready_i are both high; wr_addr_o/wr_data_o are stable while
    // wr_en_o is high and wr_ready_i is low.

    init_fsm_t         fsm_q, fsm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              auto_q, auto_d;
    logic              wr_en_q, wr_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    init_state_t       status_q, status_d;

    // Next-state, counters and the registered outputs derived from the next state.
    always_comb begin
        fsm_d  = fsm_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        auto_d = auto_q;

        case (fsm_q)
            IDLE: begin
                // The auto-start token is consumed by the first edge after reset.
                if (start_i || auto_q) begin
                    fsm_d  = CLEAR;
                    addr_d = '0;
                    auto_d = 1'b0;
                end
            end
            CLEAR: begin
                if (wr_en_q && wr_ready_i) begin
                    if (addr_q == LAST_ADDR) begin
                        // Address parks on the last entry; it never wraps.
                        if (SETTLE_CYCLES == 0) begin
                            fsm_d = DONE;
                        end else begin
                            fsm_d = SETTLE;
                            cnt_d = CNT_W'(SETTLE_LOAD);
                        end
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (start_i) begin
                    fsm_d  = CLEAR;
                    addr_d = '0;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        wr_en_d  = (fsm_d == CLEAR);
        busy_d   = (fsm_d == CLEAR) || (fsm_d == SETTLE);
        done_d   = (fsm_d == DONE) && (fsm_q != DONE);
        status_d = make_status(fsm_d == DONE);
    end

    // State and output registers; reset returns everything to the idle, uninitialized view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            auto_q   <= AUTO_START;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= make_status(1'b0);
        end else begin
            fsm_q    <= fsm_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            auto_q   <= auto_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = addr_q;
    assign wr_data_o = FILL_VALUE;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign state_o   = status_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Bench for init_sequencer: one instance with a settle period and auto start,
// one with no settle period, no auto start and a non-zero fill value.
module tb_init_sequencer;
    import init_pkg::*;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam logic [31:0] FILL_B = 32'hA5A5_A5A5;

    logic clk;
    logic rst_n;

    // Instance A: DEPTH=8, SETTLE=4, AUTO_START=1, fill 0
    logic              a_start, a_ready;
    logic              a_wr_en, a_busy, a_done;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_data;
    init_state_t       a_state;

    // Instance B: DEPTH=8, SETTLE=0, AUTO_START=0, fill A5A5A5A5
    logic              b_start, b_ready;
    logic              b_wr_en, b_busy, b_done;
    logic [ADDR_W-1:0] b_addr;
    logic [31:0]       b_data;
    init_state_t       b_state;

    int checks   = 0;
    int failures = 0;
    int done_cnt_a = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_b[$];

    init_sequencer #(
        .DEPTH(DEPTH), .DATA_W(32), .FILL_VALUE(32'h0),
        .SETTLE_CYCLES(4), .AUTO_START(1'b1)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(a_start), .wr_ready_i(a_ready),
        .wr_en_o(a_wr_en), .wr_addr_o(a_addr), .wr_data_o(a_data),
        .busy_o(a_busy), .done_o(a_done), .state_o(a_state)
    );

    init_sequencer #(
        .DEPTH(DEPTH), .DATA_W(32), .FILL_VALUE(FILL_B),
        .SETTLE_CYCLES(0), .AUTO_START(1'b0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(b_start), .wr_ready_i(b_ready),
        .wr_en_o(b_wr_en), .wr_addr_o(b_addr), .wr_data_o(b_data),
        .busy_o(b_busy), .done_o(b_done), .state_o(b_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle invariants and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        check_eq("onehot_a", 32'(a_state.INITIALIZED ^ a_state.NOT_INITIALIZED), 32'd1);
        check_eq("onehot_b", 32'(b_state.INITIALIZED ^ b_state.NOT_INITIALIZED), 32'd1);
        check_eq("data_a", a_data, 32'h0);
        check_eq("data_b", b_data, FILL_B);
        if (a_done) done_cnt_a++;
        if (rst_n && a_wr_en && a_ready) begin
            check_eq("sb_nonempty_a", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("wr_addr_a", 32'(a_addr), 32'(exp_q.pop_front()));
        end
        if (rst_n && b_wr_en && b_ready) begin
            check_eq("sb_nonempty_b", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) check_eq("wr_addr_b", 32'(b_addr), 32'(exp_b.pop_front()));
        end
    end

    task automatic push_all_a();
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(ADDR_W'(i));
    endtask

    task automatic check_reset_a(input string tag);
        check_eq({tag, "_wr_en"}, 32'(a_wr_en), 32'd0);
        check_eq({tag, "_addr"},  32'(a_addr),  32'd0);
        check_eq({tag, "_busy"},  32'(a_busy),  32'd0);
        check_eq({tag, "_done"},  32'(a_done),  32'd0);
        check_eq({tag, "_state"}, 32'(a_state), 32'd1);
    endtask

    // Runs one clear on A. With do_start the caller is at a negedge in DONE;
    // without it the caller has just released reset at a negedge.
    task automatic run_a(input bit do_start, input int stall_at, input int stall_len,
                         input bit start_mid, output int edges);
        int stalled;
        int done_base;
        done_base = done_cnt_a;
        stalled = 0;
        edges = 0;
        push_all_a();
        if (do_start) begin
            a_start = 1'b1;
            @(posedge clk); #1;
            a_start = 1'b0;
            edges = 1;
            check_eq("restart_state", 32'(a_state), 32'd1);
            check_eq("restart_wr_en", 32'(a_wr_en), 32'd1);
            check_eq("restart_busy",  32'(a_busy),  32'd1);
        end
        while (edges < 100) begin
            if (a_wr_en && (32'(a_addr) == stall_at) && (stalled < stall_len)) begin
                a_ready = 1'b0;
                stalled++;
            end else begin
                a_ready = 1'b1;
            end
            a_start = (start_mid && edges == 4);
            @(posedge clk); edges++; #1;
            if (a_state.INITIALIZED) break;
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        check_eq("init_seen_a", 32'(a_state.INITIALIZED), 32'd1);
        check_eq("init_busy_a", 32'(a_busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("done_pulses_a", 32'(done_cnt_a - done_base), 32'd1);
        check_eq("sb_drained_a", 32'(exp_q.size()), 32'd0);
        check_eq("stay_init_a", 32'(a_state), 32'd2);
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        a_start = 1'b0; a_ready = 1'b1;
        b_start = 1'b0; b_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_a("rst_a");
        check_eq("rst_b_wr_en", 32'(b_wr_en), 32'd0);
        check_eq("rst_b_state", 32'(b_state), 32'd1);

        // Auto start after reset release: 1 + DEPTH + SETTLE edges.
        rst_n = 1'b1;
        run_a(1'b0, -1, 0, 1'b0, n);
        check_eq("t1_latency", 32'(n), 32'd13);
        check_eq("b_idle_wr_en", 32'(b_wr_en), 32'd0);
        check_eq("b_idle_state", 32'(b_state), 32'd1);

        // No settle period: DONE on the edge accepting the last address.
        for (int i = 0; i < DEPTH; i++) exp_b.push_back(ADDR_W'(i));
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        n = 1;
        check_eq("b_start_wr_en", 32'(b_wr_en), 32'd1);
        while (!b_state.INITIALIZED && n < 50) begin
            @(posedge clk); n++; #1;
        end
        check_eq("b_latency", 32'(n), 32'd9);
        check_eq("b_done", 32'(b_done), 32'd1);
        check_eq("b_sb_drained", 32'(exp_b.size()), 32'd0);
        @(negedge clk);

        // Three stall cycles at address 3 add exactly three cycles.
        run_a(1'b1, 3, 3, 1'b0, n);
        check_eq("t2_latency", 32'(n), 32'd16);

        // Restart from DONE with a start pulse ignored mid-clear.
        run_a(1'b1, -1, 0, 1'b1, n);
        check_eq("t3_latency", 32'(n), 32'd13);

        // Reset asserted at address 5 aborts immediately.
        push_all_a();
        a_start = 1'b1;
        @(posedge clk); #1;
        a_start = 1'b0;
        n = 0;
        while (!(a_wr_en && a_addr == 3'd5) && n < 20) begin
            @(posedge clk); n++; #1;
        end
        check_eq("reach_addr5", 32'(a_addr), 32'd5);
        rst_n = 1'b0;
        #1;
        check_reset_a("async_rst_a");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_a(1'b0, -1, 0, 1'b0, n);
        check_eq("t5_latency", 32'(n), 32'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
